// File: rtl/axi_arb_2m1s_if.sv
// AXI-lite channel bundle (AW/W/B/AR/R) shared by the arbiter's two master-facing
// ports and its slave-facing port.
interface axi_arb_2m1s_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;
  logic                    r_ready;

  // Initiator side: drives requests, receives responses.
  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    output ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_valid, ar_ready, r_data, r_valid
  );

  // Target side: receives requests, drives responses.
  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    input  ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_valid, ar_ready, r_data, r_valid
  );
endinterface

// File: rtl/axi_arb_2m1s.sv
// Two-master (IFU read-only on m0, LSU read/write on m1), one-slave AXI-lite arbiter,
// one transaction in flight. Define AXI_ARB_RR_EN for round-robin between masters.
module axi_arb_2m1s #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  axi_arb_2m1s_if.slave   m0_if,
  axi_arb_2m1s_if.slave   m1_if,
  axi_arb_2m1s_if.master  s_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    WR1  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic wreq;
  logic r1;
  logic r0;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  // The IFU never writes; its write channel is left unconnected internally.
  logic unused_ok;
  assign unused_ok = ^{m0_if.aw_addr, m0_if.aw_valid, m0_if.w_data,
                       m0_if.w_strb, m0_if.w_valid, m0_if.b_ready};

  assign wreq    = m1_if.aw_valid && m1_if.w_valid;
  assign r1      = m1_if.ar_valid;
  assign r0      = m0_if.ar_valid;
  assign rd_data = s_if.r_data;

  assign m0_if.aw_ready = 1'b0;
  assign m0_if.w_ready  = 1'b0;
  assign m0_if.b_valid  = 1'b0;

`ifdef AXI_ARB_RR_EN
  // 1: M1 was the last master served, 0: M0.
  logic last_q, last_d;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef AXI_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef AXI_ARB_RR_EN
        // M1 yields only when M0 is also waiting and M1 had the last turn.
        if ((wreq || r1) && !(r0 && last_q)) begin
          state_d = wreq ? WR1 : RD1;
        end else if (r0) begin
          state_d = RD0;
        end
`else
        if (wreq) begin
          state_d = WR1;
        end else if (r1) begin
          state_d = RD1;
        end else if (r0) begin
          state_d = RD0;
        end
`endif
      end
      RD0: begin
        if (s_if.r_valid && m0_if.r_ready) begin
          state_d = IDLE;
`ifdef AXI_ARB_RR_EN
          last_d  = 1'b0;
`endif
        end
      end
      RD1: begin
        if (s_if.r_valid && m1_if.r_ready) begin
          state_d = IDLE;
`ifdef AXI_ARB_RR_EN
          last_d  = 1'b1;
`endif
        end
      end
      WR1: begin
        if (s_if.b_valid && m1_if.b_ready) begin
          state_d = IDLE;
`ifdef AXI_ARB_RR_EN
          last_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel routing: everything not belonging to the current owner is held at zero.
  always_comb begin
    s_if.aw_addr   = '0;
    s_if.aw_valid  = 1'b0;
    s_if.w_data    = '0;
    s_if.w_strb    = '0;
    s_if.w_valid   = 1'b0;
    s_if.b_ready   = 1'b0;
    s_if.ar_valid  = 1'b0;
    s_if.r_ready   = 1'b0;
    rd_addr        = '0;
    m0_if.ar_ready = 1'b0;
    m0_if.r_valid  = 1'b0;
    m0_if.r_data   = '0;
    m1_if.aw_ready = 1'b0;
    m1_if.w_ready  = 1'b0;
    m1_if.b_valid  = 1'b0;
    m1_if.ar_ready = 1'b0;
    m1_if.r_valid  = 1'b0;
    m1_if.r_data   = '0;
    case (state_q)
      RD0: begin
        rd_addr        = m0_if.ar_addr;
        s_if.ar_valid  = m0_if.ar_valid;
        s_if.r_ready   = m0_if.r_ready;
        m0_if.ar_ready = s_if.ar_ready;
        m0_if.r_valid  = s_if.r_valid;
        m0_if.r_data   = rd_data;
      end
      RD1: begin
        rd_addr        = m1_if.ar_addr;
        s_if.ar_valid  = m1_if.ar_valid;
        s_if.r_ready   = m1_if.r_ready;
        m1_if.ar_ready = s_if.ar_ready;
        m1_if.r_valid  = s_if.r_valid;
        m1_if.r_data   = rd_data;
      end
      WR1: begin
        s_if.aw_addr   = m1_if.aw_addr;
        s_if.aw_valid  = m1_if.aw_valid;
        s_if.w_data    = m1_if.w_data;
        s_if.w_strb    = m1_if.w_strb;
        s_if.w_valid   = m1_if.w_valid;
        s_if.b_ready   = m1_if.b_ready;
        m1_if.aw_ready = s_if.aw_ready;
        m1_if.w_ready  = s_if.w_ready;
        m1_if.b_valid  = s_if.b_valid;
      end
      default: ;
    endcase
    s_if.ar_addr = rd_addr;
  end

endmodule

// File: tb/tb_axi_arb_2m1s.sv
// Directed bench for axi_arb_2m1s: SRAM slave model, transaction-level ownership model
// compared every cycle, plus literal checks on latency, data, order and reset.
module tb_axi_arb_2m1s;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int M_IDLE = 0, M_RD0 = 1, M_RD1 = 2, M_WR1 = 3;
  localparam logic [63:0] MEM0 = 64'hDEAD_BEEF_0123_4567;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi_arb_2m1s_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0 ();
  axi_arb_2m1s_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1 ();
  axi_arb_2m1s_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s ();

  axi_arb_2m1s #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .resetn_i(resetn), .m0_if(m0), .m1_if(m1), .s_if(s)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // ---------------- SRAM slave model ----------------
  logic [63:0] mem [0:63];
  logic rd_pend = 1'b0, wr_pend = 1'b0, stall_b = 1'b0, slv_clear = 1'b1;
  logic [63:0] rdata = '0;

  assign s.ar_ready = !rd_pend;
  assign s.r_valid  = rd_pend;
  assign s.r_data   = rd_pend ? rdata : 64'h0;
  assign s.aw_ready = !wr_pend;
  assign s.w_ready  = !wr_pend;
  assign s.b_valid  = wr_pend && !stall_b;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 0) ? MEM0 : 64'h0;
    end else if (!wr_pend && s.aw_valid && s.w_valid) begin
      for (int b = 0; b < 8; b++)
        if (s.w_strb[b]) mem[s.aw_addr[8:3]][8*b +: 8] <= s.w_data[8*b +: 8];
    end
    if (slv_clear) begin
      rd_pend <= 1'b0; wr_pend <= 1'b0; rdata <= '0;
    end else begin
      if (!rd_pend && s.ar_valid) begin
        rd_pend <= 1'b1; rdata <= mem[s.ar_addr[8:3]];
      end else if (rd_pend && s.r_ready) rd_pend <= 1'b0;
      if (!wr_pend && s.aw_valid && s.w_valid) wr_pend <= 1'b1;
      else if (s.b_valid && s.b_ready) wr_pend <= 1'b0;
    end
  end

  // ---------------- ownership model ----------------
  int mo = M_IDLE;
  int last_served = 0;   // 0: M0, 1: M1

  always @(posedge clk) begin : model
    bit w, q1, q0;
    int take;
    if (!resetn) begin
      mo <= M_IDLE; last_served <= 0;
    end else begin
      w  = m1.aw_valid && m1.w_valid;
      q1 = w || m1.ar_valid;
      q0 = m0.ar_valid;
      case (mo)
        M_IDLE: begin
          take = q1 ? 1 : (q0 ? 0 : -1);
`ifdef AXI_ARB_RR_EN
          if (q1 && q0) take = (last_served == 0) ? 1 : 0;
`endif
          if (take == 1) mo <= w ? M_WR1 : M_RD1;
          else if (take == 0) mo <= M_RD0;
        end
        M_RD0: if (s.r_valid && m0.r_ready) begin mo <= M_IDLE; last_served <= 0; end
        M_RD1: if (s.r_valid && m1.r_ready) begin mo <= M_IDLE; last_served <= 1; end
        M_WR1: if (s.b_valid && m1.b_ready) begin mo <= M_IDLE; last_served <= 1; end
        default: mo <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    logic rd0, rd1, wr1;
    rd0 = (mo == M_RD0); rd1 = (mo == M_RD1); wr1 = (mo == M_WR1);
    check("m0_out", {m0.aw_ready, m0.w_ready, m0.b_valid, m0.ar_ready, m0.r_valid, m0.r_data},
          {3'b000, rd0 & s.ar_ready, rd0 & s.r_valid, rd0 ? s.r_data : 64'h0});
    check("m1_out", {m1.aw_ready, m1.w_ready, m1.b_valid, m1.ar_ready, m1.r_valid, m1.r_data},
          {wr1 & s.aw_ready, wr1 & s.w_ready, wr1 & s.b_valid,
           rd1 & s.ar_ready, rd1 & s.r_valid, rd1 ? s.r_data : 64'h0});
    check("s_out", {s.aw_addr, s.aw_valid, s.w_data, s.w_strb, s.w_valid, s.b_ready,
                    s.ar_addr, s.ar_valid, s.r_ready},
          {wr1 ? m1.aw_addr : 64'h0, wr1 & m1.aw_valid, wr1 ? m1.w_data : 64'h0,
           wr1 ? m1.w_strb : 8'h0, wr1 & m1.w_valid, wr1 & m1.b_ready,
           rd0 ? m0.ar_addr : (rd1 ? m1.ar_addr : 64'h0),
           (rd0 & m0.ar_valid) | (rd1 & m1.ar_valid), (rd0 & m0.r_ready) | (rd1 & m1.r_ready)});
  end

  // ---------------- grant monitor ----------------
  int g_owner[$];
  int g_gap[$];
  int idle_run = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin : mon
    logic busy;
    busy = s.aw_valid || s.ar_valid;
    if (busy && !busy_prev) begin
      g_owner.push_back(s.aw_valid ? M_WR1 : ((m1.ar_ready || m1.r_valid) ? M_RD1 : M_RD0));
      g_gap.push_back(idle_run);
    end
    idle_run  = busy ? 0 : idle_run + 1;
    busy_prev = busy;
  end

  // ---------------- master tasks ----------------
  task automatic m0_read(input logic [63:0] addr, output logic [63:0] data, output int lat);
    bit got;
    got = 0; lat = -1; data = '0;
    m0.ar_addr = addr; m0.ar_valid = 1'b1; m0.r_ready = 1'b1;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (lat < 0 && s.ar_valid && m0.ar_ready) lat = i;
      if (m0.r_valid) begin got = 1; data = m0.r_data; end
    end
    check("m0_read_done", got, 1'b1);
    @(negedge clk);
    m0.ar_valid = 1'b0; m0.r_ready = 1'b0; m0.ar_addr = '0;
  endtask

  task automatic m1_read(input logic [63:0] addr, output logic [63:0] data);
    bit got;
    got = 0; data = '0;
    m1.ar_addr = addr; m1.ar_valid = 1'b1; m1.r_ready = 1'b1;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (m1.r_valid) begin got = 1; data = m1.r_data; end
    end
    check("m1_read_done", got, 1'b1);
    @(negedge clk);
    m1.ar_valid = 1'b0; m1.r_ready = 1'b0; m1.ar_addr = '0;
  endtask

  task automatic m1_write(input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, output logic [7:0] strb_seen);
    bit got, seen;
    got = 0; seen = 0; strb_seen = '0;
    m1.aw_addr = addr; m1.w_data = data; m1.w_strb = strb;
    m1.aw_valid = 1'b1; m1.w_valid = 1'b1; m1.b_ready = 1'b1;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (!seen && s.w_valid) begin seen = 1; strb_seen = s.w_strb; end
      if (m1.b_valid) got = 1;
    end
    check("m1_write_done", got, 1'b1);
    @(negedge clk);
    m1.aw_valid = 1'b0; m1.w_valid = 1'b0; m1.b_ready = 1'b0;
    m1.aw_addr = '0; m1.w_data = '0; m1.w_strb = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] d0, d1;
    logic [7:0] st;
    int lat, n;

    m0.aw_addr = '0; m0.aw_valid = 0; m0.w_data = '0; m0.w_strb = '0; m0.w_valid = 0;
    m0.b_ready = 0; m0.ar_addr = '0; m0.ar_valid = 0; m0.r_ready = 0;
    m1.aw_addr = '0; m1.aw_valid = 0; m1.w_data = '0; m1.w_strb = '0; m1.w_valid = 0;
    m1.b_ready = 0; m1.ar_addr = '0; m1.ar_valid = 0; m1.r_ready = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1; slv_clear = 1'b0;
    @(negedge clk);

    // Reset in the middle of a write whose B is held back by the slave.
    stall_b = 1'b1;
    m1.aw_addr = 64'h8000_0100; m1.w_data = 64'hA5A5_A5A5_A5A5_A5A5; m1.w_strb = 8'hFF;
    m1.aw_valid = 1'b1; m1.w_valid = 1'b1; m1.b_ready = 1'b1;
    n = 0;
    while (!s.aw_valid && n < 20) begin @(negedge clk); n++; end
    check("wr1_granted", s.aw_valid, 1'b1);
    repeat (2) @(negedge clk);
    resetn = 1'b0; m1.aw_valid = 1'b0; m1.w_valid = 1'b0;
    @(negedge clk);
    check("rst_m0", {m0.aw_ready, m0.w_ready, m0.b_valid, m0.ar_ready, m0.r_valid, m0.r_data}, '0);
    check("rst_m1", {m1.aw_ready, m1.w_ready, m1.b_valid, m1.ar_ready, m1.r_valid, m1.r_data}, '0);
    check("rst_s", {s.aw_addr, s.aw_valid, s.w_data, s.w_strb, s.w_valid, s.b_ready,
                    s.ar_addr, s.ar_valid, s.r_ready}, '0);
    resetn = 1'b1; stall_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_b_after_rst", m1.b_valid, 1'b0);
    end
    slv_clear = 1'b1; m1.b_ready = 1'b0;
    @(negedge clk);
    slv_clear = 1'b0;

    // Lone IFU read.
    m0_read(64'h8000_0000, d0, lat);
    check("ifu_grant_latency", lat, 1);
    check("ifu_read_data", d0, MEM0);

    // LSU partial write then IFU readback.
    m1_write(64'h8000_0010, 64'h1122_3344_5566_7788, 8'h0F, st);
    check("lsu_wr_strobe", st, 8'h0F);
    m0_read(64'h8000_0010, d0, lat);
    check("readback_strobed", d0, 64'h0000_0000_5566_7788);

    // All three requests in the same idle cycle.
    g_owner.delete(); g_gap.delete();
    fork
      m1_write(64'h8000_0020, 64'h0102_0304_0506_0708, 8'hFF, st);
      m1_read(64'h8000_0000, d1);
      m0_read(64'h8000_0010, d0, lat);
    join
    check("prio_count", g_owner.size(), 3);
    if (g_owner.size() >= 3) begin
      check("prio_first_wr1", g_owner[0], M_WR1);
      check("prio_second_rd1", g_owner[1], M_RD1);
      check("prio_third_rd0", g_owner[2], M_RD0);
      check("prio_bubble_1", g_gap[1], 1);
      check("prio_bubble_2", g_gap[2], 1);
    end
    check("prio_rd1_data", d1, MEM0);
    check("prio_rd0_data", d0, 64'h0000_0000_5566_7788);

    // IFU requests while the LSU write is outstanding.
    g_owner.delete(); g_gap.delete();
    stall_b = 1'b1;
    fork
      m1_write(64'h8000_0028, 64'hFFFF_0000_FFFF_0000, 8'hFF, st);
      begin
        n = 0;
        while (!s.aw_valid && n < 20) begin @(negedge clk); n++; end
        check("e_wr1_granted", s.aw_valid, 1'b1);
        fork
          m0_read(64'h8000_0010, d0, lat);
          begin
            for (int i = 0; i < 4; i++) begin
              @(negedge clk);
              check("m0_stalled_in_wr1", {m0.ar_ready, m0.r_valid}, 2'b00);
            end
            @(posedge clk);
            #1 stall_b = 1'b0;
          end
        join
      end
    join
    check("e_count", g_owner.size(), 2);
    if (g_owner.size() >= 2) begin
      check("e_first_wr1", g_owner[0], M_WR1);
      check("e_then_rd0", g_owner[1], M_RD0);
      check("e_bubble", g_gap[1], 1);
    end
    check("e_rd0_data", d0, 64'h0000_0000_5566_7788);

`ifdef AXI_ARB_RR_EN
    // Round-robin: both masters reading back to back right after reset.
    resetn = 1'b0; slv_clear = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1; slv_clear = 1'b0;
    g_owner.delete(); g_gap.delete();
    fork
      begin
        m1_read(64'h8000_0000, d1);
        m1_read(64'h8000_0008, d1);
      end
      begin
        m0_read(64'h8000_0000, d0, lat);
        m0_read(64'h8000_0008, d0, lat);
      end
    join
    check("rr_count", g_owner.size(), 4);
    if (g_owner.size() >= 4) begin
      check("rr_0_rd1", g_owner[0], M_RD1);
      check("rr_1_rd0", g_owner[1], M_RD0);
      check("rr_2_rd1", g_owner[2], M_RD1);
      check("rr_3_rd0", g_owner[3], M_RD0);
    end
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/axi_arb_2m1s.md
# axi_arb_2m1s

Two-master, one-slave AXI-lite arbiter placed between the IFU, the LSU and the shared SRAM slave. It serialises all memory traffic with at most one outstanding transaction in flight. Read requests from both masters and write requests from the LSU are granted by a small state machine. The granted master's channels are routed to the slave, and the other master is stalled.

## Interface
Parameters:
- ADDR_WIDTH, 64, address width on all ports
- DATA_WIDTH, 64, data width; strobe width DATA_WIDTH/8

Ports (channel groups listed as name/name/name, with matching directions and widths):
- CLK  in  1  single clock, all logic on posedge
- RESETN  in  1  synchronous, active-low reset
- M0_AR_ADDR/M0_AR_VALID/M0_AR_READY  in/in/out  ADDR_WIDTH/1/1  IFU read address
- M0_R_DATA/M0_R_VALID/M0_R_READY  out/out/in  DATA_WIDTH/1/1  IFU read data
- M1_AW_ADDR/M1_AW_VALID/M1_AW_READY  in/in/out  ADDR_WIDTH/1/1  LSU write address
- M1_W_DATA/M1_W_STRB/M1_W_VALID/M1_W_READY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  LSU write data
- M1_B_VALID/M1_B_READY  out/in  1/1  LSU write response
- M1_AR_ADDR/M1_AR_VALID/M1_AR_READY  in/in/out  ADDR_WIDTH/1/1  LSU read address
- M1_R_DATA/M1_R_VALID/M1_R_READY  out/out/in  DATA_WIDTH/1/1  LSU read data
- S_AW_*, S_W_*, S_B_*, S_AR_*, S_R_*  mirror of the M1 channel set, opposite directions, to the SRAM slave

## Operation
- States: IDLE, RD0 (IFU read owns the slave), RD1 (LSU read), WR1 (LSU write).
- Request terms, evaluated only in IDLE:
  - wreq = M1_AW_VALID && M1_W_VALID
  - r1 = M1_AR_VALID
  - r0 = M0_AR_VALID
- Default fixed priority: wreq > r1 > r0. An AW_VALID without W_VALID (or the reverse) is not a request.
- IDLE -> WR1, RD1 or RD0 on the winning request. IDLE stays IDLE when there is no request.
- In a grant state, the owner's channel signals pass combinationally to the slave, and the slave's signals pass back to the owner.
  - Owner READY lines equal the slave READY lines.
  - Owner R_DATA equals S_R_DATA.
- Forced to 0 in every state:
  - All slave-bound VALID/READY lines not belonging to the owner.
  - All non-owner master-bound VALID/READY lines.
  - Non-owner R_DATA.
- S_*_ADDR, S_W_DATA and S_W_STRB are muxed from the owner. They are 0 in IDLE.
- RD0/RD1 -> IDLE after the cycle in which S_R_VALID && owner R_READY are both high.
- WR1 -> IDLE after the cycle in which S_B_VALID && M1_B_READY are both high.
- The owner must hold AR_VALID (read) or AW/W_VALID (write) until its R/B handshake completes; the slave samples address and data only while they are high.
  - A master dropping VALID early is a protocol violation.
  - The grant is held regardless; there is no timeout.
- Requests arriving while the slave is busy are not queued. They stay pending on the master (VALID held) and are re-evaluated in IDLE.

## Timing
- Reset (RESETN=0 at posedge): state -> IDLE.
  - All outputs are 0 in the same cycle as IDLE: every master READY/VALID, every slave VALID/READY, and all data, address and strobe lines.
  - Reset mid-transaction abandons it. No B/R is delivered afterwards.
- Grant latency: a request visible in IDLE at edge N gives the grant state from edge N+1. Slave-side VALID is high in that cycle.
- Release: the completing handshake at cycle M gives IDLE during M+1, and the next grant at M+2. There is exactly one idle bubble between transactions.
- Simultaneous wreq, r1 and r0 in IDLE: the grant follows the priority rule. Losers see READY=0 and keep VALID.
- Slave R_DATA is 0 outside its read handshake. The arbiter forwards it unchanged to the owner only.

## Configuration
- AXI_ARB_RR_EN undefined: fixed priority wreq > r1 > r0. The IFU can starve under continuous LSU traffic.
- AXI_ARB_RR_EN defined: round-robin between masters.
  - A 1-bit last-owner register is updated on each transition into IDLE from a grant state. Its reset value is 0 (M0 last served).
  - When M0 and M1 both request, the master not last served wins.
  - Inside M1, wreq still beats r1.
  - The single-requester case is the same as fixed priority.

## Test plan
- Reset mid-WR1 (write granted, B not yet returned), then release RESETN → all outputs 0 in the reset cycle; state IDLE; no M1_B_VALID afterwards.
- Lone IFU read of 0x8000_0000, held until R handshake → S_AR_VALID rises one cycle after M0_AR_VALID; M0_R_DATA equals the memory word at the handshake; M1 readies stay 0 throughout.
- LSU write 0x8000_0010, data 0x1122334455667788, strobe 0x0F → slave write forwarded with strobe 0x0F; M1_B_VALID pulses; readback by IFU returns 0x0000000055667788 when memory was pre-zeroed.
- r0, r1 and wreq asserted in the same IDLE cycle (fixed priority) → order of service WR1, RD1, RD0, each separated by one IDLE cycle.
- With AXI_ARB_RR_EN: M0 and M1 reading continuously → grants alternate starting with M1 after reset: RD1, RD0, RD1, RD0.
- Non-owner M0 asserting AR_VALID during WR1 → M0_AR_READY=0 and M0_R_VALID=0 until WR1 completes; M0 is granted on the following IDLE.
